// File: rtl/wb_regfile_if.sv
// MEM/WB -> writeback/register-file bundle.
// The master side is the MEM/WB pipeline register together with the ID stage.
// The slave side is wb_regfile.
// Signal names follow the pipeline's established port names.
// Those names keep their _i/_o suffixes so that they match the surrounding datapath.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  // Writeback control from MEM/WB: bit1 RegWrite, bit0 MemtoReg
  logic [1:0]        WB_i;
  logic [DATA_W-1:0] ReadMem_i;
  logic [DATA_W-1:0] ALUresult_i;
  logic [ADDR_W-1:0] RegRD_i;

  // ID-stage read ports
  logic [ADDR_W-1:0] RS_addr_i;
  logic [ADDR_W-1:0] RT_addr_i;
  logic [DATA_W-1:0] RS_data_o;
  logic [DATA_W-1:0] RT_data_o;

  // Forwarding-unit view of the writeback stage, plus debug counter
  logic [DATA_W-1:0] WBdata_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] RegRD_o;
  logic [CNT_W-1:0]  wb_count_o;

  modport master (
    output WB_i, ReadMem_i, ALUresult_i, RegRD_i, RS_addr_i, RT_addr_i,
    input  RS_data_o, RT_data_o, WBdata_o, RegWrite_o, RegRD_o, wb_count_o
  );

  modport slave (
    input  WB_i, ReadMem_i, ALUresult_i, RegRD_i, RS_addr_i, RT_addr_i,
    output RS_data_o, RT_data_o, WBdata_o, RegWrite_o, RegRD_o, wb_count_o
  );

endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
//
// The block selects the writeback value from the load data or the ALU result.
// It commits that value to entry RegRD_i on the rising edge of clk_i.
// Entry 0 is hardwired to zero.
// Two combinational read ports serve the ID stage.
// A saturating counter tallies the committed writes for debug.
//
// Optional feature: define WB_REGFILE_BYPASS_EN for write-before-read bypass.
// With it, a read port that addresses the register being written in the
// current cycle sees the new value before the commit edge.
// Without it, the new value becomes visible only after the edge.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  wb_regfile_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] wb_data;
  logic              we;
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  wb_count;
  logic              rs_hit;
  logic              rt_hit;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Writeback value select and effective write enable (x0 writes suppressed)
  always_comb begin
    wb_data = bus.WB_i[0] ? bus.ReadMem_i : bus.ALUresult_i;
    we      = bus.WB_i[1] & (bus.RegRD_i != '0);
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Same-cycle hit on the register being written: read sees wb_data
  always_comb begin
    rs_hit = we & (bus.RS_addr_i == bus.RegRD_i);
    rt_hit = we & (bus.RT_addr_i == bus.RegRD_i);
  end
`else
  // No bypass: reads only ever see committed contents
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
  end
`endif

  // Register storage; reset clears every entry at once, independent of the clock
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[bus.RegRD_i] <= wb_data;
    end
  end

  // Saturating commit counter; only effective writes are counted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_count <= '0;
    end else if (we && (wb_count != '1)) begin
      wb_count <= wb_count + CNT_ONE;
    end
  end

  // Read port A: x0 reads as zero, then bypass, then stored value
  always_comb begin
    rs_data = '0;
    if (bus.RS_addr_i != '0) begin
      rs_data = rs_hit ? wb_data : regs[bus.RS_addr_i];
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rt_data = '0;
    if (bus.RT_addr_i != '0) begin
      rt_data = rt_hit ? wb_data : regs[bus.RT_addr_i];
    end
  end

  // Drive the interface outputs
  always_comb begin
    bus.RS_data_o  = rs_data;
    bus.RT_data_o  = rt_data;
    bus.WBdata_o   = wb_data;
    bus.RegWrite_o = we;
    bus.RegRD_o    = bus.RegRD_i;
    bus.wb_count_o = wb_count;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile.
//
// The driver changes the inputs on each falling edge, as MEM/WB does.
// Each time it drives a vector, it pushes the expected pre-commit outputs onto a queue.
// The expected values come from an array model of the register file.
// The monitor pops one entry 3 time units after each falling edge and compares it with the DUT outputs.
// The counter is built with CNT_W=2 so that saturation is reached quickly.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    string       tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wbd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  exp_t        q[$];
  logic [31:0] mdl [32];
  int          mcnt;
  int          n_vec;
  int          n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] rd, input logic [31:0] wbd);
    if (a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (we && a == rd) return wbd;
`endif
    return mdl[a];
  endfunction

  task automatic step(input string tag, input bit rst, input logic [1:0] wb,
                      input logic [31:0] mem, input logic [31:0] alu,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    exp_t        e;
    logic [31:0] wbd;
    bit          we;
    @(negedge clk);
    rst_n           = rst;
    bus.WB_i        = wb;
    bus.ReadMem_i   = mem;
    bus.ALUresult_i = alu;
    bus.RegRD_i     = rd;
    bus.RS_addr_i   = rs;
    bus.RT_addr_i   = rt;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mcnt = 0;
    end
    wbd   = wb[0] ? mem : alu;
    we    = wb[1] && (rd != 5'd0);
    e.tag = tag;
    e.rs  = ref_read(rs, we, rd, wbd);
    e.rt  = ref_read(rt, we, rd, wbd);
    e.wbd = wbd;
    e.we  = we;
    e.rd  = rd;
    e.cnt = mcnt;
    q.push_back(e);
    // The commit lands on the coming rising edge, provided reset is released
    if (rst && we) begin
      mdl[rd] = wbd;
      if (mcnt < CMAX) mcnt++;
    end
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s.%s: got %h expected %h at %0t", tag, field, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT outputs with the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk(e.tag, "RS_data",  bus.RS_data_o, e.rs);
        chk(e.tag, "RT_data",  bus.RT_data_o, e.rt);
        chk(e.tag, "WBdata",   bus.WBdata_o, e.wbd);
        chk(e.tag, "RegWrite", {31'h0, bus.RegWrite_o}, {31'h0, e.we});
        chk(e.tag, "RegRD",    {27'h0, bus.RegRD_o}, {27'h0, e.rd});
        chk(e.tag, "wb_count", {30'h0, bus.wb_count_o}, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, pending %0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  rd, rs, rt;
    logic [1:0]  wb;
    bit          rbit;
    n_vec = 0;
    n_mis = 0;
    mcnt  = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n           = 1'b0;
    bus.WB_i        = 2'b00;
    bus.ReadMem_i   = '0;
    bus.ALUresult_i = '0;
    bus.RegRD_i     = '0;
    bus.RS_addr_i   = '0;
    bus.RT_addr_i   = '0;

    step("reset0", 0, 2'b00, 0, 0, 0, 0, 0);
    step("reset1", 0, 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      step("reset_rd", 1, 2'b00, 0, 0, 0, 5'(i), 5'(31 - i));

    step("alu_wr",   1, 2'b10, 32'h0, 32'h0000_1234, 5'd7, 5'd0, 5'd0);
    step("alu_rd",   1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    step("load_wr",  1, 2'b11, 32'hDEAD_BEEF, 32'h5, 5'd3, 5'd3, 5'd7);
    step("load_rd",  1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    step("x0_wr",    1, 2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    step("x0_rd",    1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
    step("byp_init", 1, 2'b10, 32'h0, 32'h1, 5'd9, 5'd0, 5'd0);
    step("byp_pre",  1, 2'b10, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9);
    step("byp_post", 1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    step("b2b_a",    1, 2'b10, 32'h0, 32'h11, 5'd4, 5'd4, 5'd0);
    step("b2b_b",    1, 2'b10, 32'h0, 32'h22, 5'd4, 5'd4, 5'd0);
    step("b2b_rd",   1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);

    step("r5_wr",    1, 2'b10, 32'h0, 32'hA, 5'd5, 5'd0, 5'd0);
    step("r5_rd",    1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    step("rst_mid",  0, 2'b10, 32'h0, 32'h77, 5'd6, 5'd5, 5'd6);
    step("rst_rel",  1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);

    for (int i = 1; i <= 5; i++)
      step("sat_wr", 1, 2'b10, 32'h0, 32'(i * 3), 5'(i + 10), 5'(i + 10), 5'd0);
    step("sat_rd",   1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd11, 5'd15);

    for (int n = 0; n < 3000; n++) begin
      rbit = ($urandom_range(0, 99) >= 2);
      wb   = 2'($urandom);
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rs   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      rt   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      step("random", rbit, wb, $urandom, $urandom, rd, rs, rt);
    end

    repeat (3) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d entries left in queue, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
